// File: rtl/ex_result_pkg.sv
// Shared op codes, entry layout and result resolution
// for the execute-stage result register.
package ex_result_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] EX_OP_ARITH = 4'd0;
  localparam logic [3:0] EX_OP_SLT   = 4'd1;
  localparam logic [3:0] EX_OP_SLTU  = 4'd2;
  localparam logic [3:0] EX_OP_BEQ   = 4'd8;
  localparam logic [3:0] EX_OP_BNE   = 4'd9;
  localparam logic [3:0] EX_OP_BLT   = 4'd10;
  localparam logic [3:0] EX_OP_BGE   = 4'd11;
  localparam logic [3:0] EX_OP_BLTU  = 4'd12;
  localparam logic [3:0] EX_OP_BGEU  = 4'd13;

  typedef struct packed {
    logic            illegal;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            taken;
    logic [XLEN-1:0] target;
  } ex_ent_t;

  localparam int ENT_W = $bits(ex_ent_t);

  function automatic ex_ent_t ex_resolve(
    input logic [3:0]      op,
    input logic [4:0]      rd,
    input logic [XLEN-1:0] target,
    input logic [XLEN-1:0] y,
    input logic            altb,
    input logic            altbu,
    input logic            zero
  );
    ex_ent_t r;
    logic    tk;
    r    = '0;
    tk   = 1'b0;
    r.rd = rd;
    unique case (op)
      EX_OP_ARITH: begin
        r.data = y;
        r.we   = |rd;
      end
      EX_OP_SLT: begin
        r.data = XLEN'(altb);
        r.we   = |rd;
      end
      EX_OP_SLTU: begin
        r.data = XLEN'(altbu);
        r.we   = |rd;
      end
      EX_OP_BEQ:  tk = zero;
      EX_OP_BNE:  tk = ~zero;
      EX_OP_BLT:  tk = altb;
      EX_OP_BGE:  tk = ~altb;
      EX_OP_BLTU: tk = altbu;
      EX_OP_BGEU: tk = ~altbu;
      default: begin
        r.illegal = 1'b1;
        r.rd      = '0;
      end
    endcase
    r.taken  = tk;
    r.target = tk ? target : '0;
    return r;
  endfunction

endpackage

// File: rtl/ex_result_fifo.sv
// Generic DEPTH x W register FIFO with occupancy count
// and synchronous flush.
module ex_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_ready_i,
  output logic [W-1:0]               pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign push_ready_o = ~reset & (count_q != CW'(DEPTH));
  assign push = push_valid_i & push_ready_o & ~flush_i;
  assign pop  = (count_q != '0) & pop_ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage result register: resolves SLT/branch results
// and buffers them for writeback over valid/ready.
module ex_result_stage
  import ex_result_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_target,
  input  logic [XLEN-1:0] in_y,
  input  logic            in_altb,
  input  logic            in_altbu,
  input  logic            in_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);

  ex_ent_t                    ent_in, head_raw, head;
  logic [ENT_W-1:0]           head_bits;
  logic [$clog2(DEPTH+1)-1:0] count;

  assign ent_in = ex_resolve(in_op, in_rd, in_target, in_y,
                             in_altb, in_altbu, in_zero);

  ex_result_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_data_i  (ent_in),
    .pop_ready_i  (out_ready),
    .pop_data_o   (head_bits),
    .count_o      (count)
  );

  // Stale storage must never leak out once the FIFO drains.
  assign out_valid = (count != '0);
  assign head_raw  = ex_ent_t'(head_bits);
  assign head      = out_valid ? head_raw : '0;

  assign wb_we     = head.we;
  assign wb_rd     = head.rd;
  assign wb_data   = head.data;
  assign br_taken  = head.taken;
  assign br_target = head.target;
  assign illegal   = head.illegal;

endmodule
